pe_mem_responder: RTL and testbench
===================================

# pe_mem_responder

Memory-side responder for the PE core's simplified memory port. It accepts single outstanding read/write requests of one 256-bit word, services them from an internal word-addressed scratchpad after a programmable fixed latency, and returns a one-cycle acknowledge with read data. It sits between the PE's `mem_req_o`/`data_o` outputs and its `mem_ack_i`/`data_i` inputs, serving as the local buffer model for PE-level integration and verification.

## Interface

Parameters:
- `LINE_WIDTH`, 256: data word width in bits.
- `ADDR_WIDTH`, 32: request address width; byte address.
- `DEPTH`, 64: number of scratchpad words; power of two, ≥2.
- `LATENCY`, 2: BUSY cycles between capture and acknowledge; range 1..15.

Ports:
- `clk` input 1: single clock. Everything is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `mem_req_i` input 1: request valid, from PE `mem_req_o`.
- `mem_we_i` input 1: 1 = write, 0 = read; sampled with `mem_req_i`.
- `addr_i` input ADDR_WIDTH: byte address, sampled with `mem_req_i`.
- `wdata_i` input LINE_WIDTH: write data, from PE `data_o`, sampled with `mem_req_i`.
- `mem_ack_o` output 1: one-cycle completion pulse, to PE `mem_ack_i`.
- `rdata_o` output LINE_WIDTH: read data, to PE `data_i`; valid when `mem_ack_o` is high for a read.
- `err_o` output 1: out-of-range flag; valid only while `mem_ack_o` is high.
- `busy_o` output 1: high in BUSY and ACK; a request is not accepted.

## Operation

- FSM states: IDLE, BUSY, ACK.
- **IDLE:** if `mem_req_i`=1, capture `mem_we_i`, `addr_i` and `wdata_i` into holding registers, load the latency counter with LATENCY−1, and go to BUSY. Otherwise stay in IDLE.
- **BUSY:** decrement the counter each cycle. At count 0, go to ACK. Input changes in BUSY are ignored.
- **ACK:** `mem_ack_o`=1 for exactly this cycle, then go to IDLE unconditionally.
- **Word index** = captured `addr[$clog2(DEPTH)+4:5]`. `addr[4:0]` is ignored; no alignment error is raised.
- **Out of range:** captured address ≥ DEPTH×32. `err_o`=1 in ACK. A write is dropped. A read returns `rdata_o`=0.
- **Write:** the array word is updated at the BUSY→ACK edge. `rdata_o` is unchanged.
- **Read:** `rdata_o` is loaded from the array at the BUSY→ACK edge. It holds its value until the next read ack or reset.
- **Requester rule:** hold `mem_req_i` until the ack is seen, and deassert it in the cycle after ack. A request still high in the IDLE cycle after ACK is taken as a new request (back-to-back is legal).
- **Reset mid-operation:** return to IDLE. No ack is issued and a pending write is discarded. Array contents are not reset (undefined until written).

## Timing

- Reset values: `mem_ack_o`=0, `rdata_o`=0, `err_o`=0, `busy_o`=0, FSM=IDLE, counter=0.
- All outputs are registered; no combinational path from input to output.
- Request sampled high in IDLE at cycle 0:
  - BUSY in cycles 1..LATENCY.
  - `mem_ack_o`=1 in cycle LATENCY+1.
  - IDLE in cycle LATENCY+2.
- Request-to-ack latency is LATENCY+1 cycles. Minimum request spacing is LATENCY+2 cycles.
- `busy_o` is high in cycles 1..LATENCY+1.
- A read of a word written by the previous request returns the new data. The write completes before the read is captured.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 cycles with `mem_req_i`=1 → all outputs 0, no ack. After release with `mem_req_i`=0 → stays IDLE, `busy_o`=0.
- **Write then read, LATENCY=2:** write addr 0x40, data {8{32'hDEADBEEF}}; ack exactly 3 cycles after capture, `err_o`=0. Read 0x40 → ack 3 cycles later, `rdata_o`={8{32'hDEADBEEF}}, held after ack.
- **Address aliasing/low bits:** write 0x20 with data A, then read 0x3F → `rdata_o`=A. Read 0x0 → data of word 0 is unaffected by the 0x20 write.
- **Out of range (DEPTH=64):** write 0x800 with data B → ack with `err_o`=1. Read 0x800 → `rdata_o`=0, `err_o`=1. Read 0x0 → unchanged.
- **Back-to-back:** keep `mem_req_i` high across ack → second request captured in the IDLE cycle after ACK; acks are exactly LATENCY+2 cycles apart. Inputs toggled during BUSY do not affect the result.
- **Reset mid-operation:** assert `rst_n`=0 during BUSY of a write to 0x60 → no ack. After reset, write 0x60 with C and read 0x60 → `rdata_o`=C. Also cover LATENCY=1 (ack 2 cycles after capture).

Source files
------------

// File: rtl/pe_mem_responder.sv
// rtl/pe_mem_responder.sv - single-outstanding 256-bit scratchpad responder for the PE memory port
module pe_mem_responder #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_req_i,
    input  logic                  mem_we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LINE_WIDTH-1:0] wdata_i,
    output logic                  mem_ack_o,
    output logic [LINE_WIDTH-1:0] rdata_o,
    output logic                  err_o,
    output logic                  busy_o
);
    localparam int         IDX_W    = $clog2(DEPTH);
    localparam int         IDX_LSB  = 5;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ACK} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic                  capture, finish;
    logic                  we_q, oor_q;
    logic [IDX_W-1:0]      idx_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] mem [DEPTH];

    // Byte offset within a word carries no meaning for this port.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^addr_i[IDX_LSB-1:0];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        finish    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_req_i) begin
                    state_nxt = ST_BUSY;
                    cnt_nxt   = CNT_LOAD;
                    capture   = 1'b1;
                end
            end
            ST_BUSY: begin
                if (cnt == 4'd0) begin
                    state_nxt = ST_ACK;
                    finish    = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            oor_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            mem_ack_o <= 1'b0;
            busy_o    <= 1'b0;
            err_o     <= 1'b0;
            rdata_o   <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            mem_ack_o <= (state_nxt == ST_ACK);
            busy_o    <= (state_nxt != ST_IDLE);
            err_o     <= finish & oor_q;
            if (capture) begin
                we_q    <= mem_we_i;
                oor_q   <= |addr_i[ADDR_WIDTH-1:IDX_W+IDX_LSB];
                idx_q   <= addr_i[IDX_W+IDX_LSB-1:IDX_LSB];
                wdata_q <= wdata_i;
            end
            if (finish && !we_q) begin
                rdata_o <= oor_q ? '0 : mem[idx_q];
            end
        end
    end

    // Array is deliberately left out of reset; a reset mid-write never reaches finish.
    always_ff @(posedge clk) begin
        if (finish && we_q && !oor_q) begin
            mem[idx_q] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_pe_mem_responder.sv
// tb/tb_pe_mem_responder.sv - randomized model-checked bench for pe_mem_responder (LATENCY 2 and 1)
module tb_pe_mem_responder;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req [2];
    logic         we [2];
    logic [31:0]  addr [2];
    logic [255:0] wdata [2];
    logic         ack [2];
    logic         err [2];
    logic         busy [2];
    logic [255:0] rdata [2];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    pe_mem_responder #(.LATENCY(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .mem_req_i(req[0]), .mem_we_i(we[0]), .addr_i(addr[0]),
        .wdata_i(wdata[0]), .mem_ack_o(ack[0]), .rdata_o(rdata[0]), .err_o(err[0]), .busy_o(busy[0])
    );
    pe_mem_responder #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem_req_i(req[1]), .mem_we_i(we[1]), .addr_i(addr[1]),
        .wdata_i(wdata[1]), .mem_ack_o(ack[1]), .rdata_o(rdata[1]), .err_o(err[1]), .busy_o(busy[1])
    );

    always #5 clk = ~clk;

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic [255:0] r256();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string nm, input int i, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cycle %0d: got %h expected %h", nm, i, cyc, got, exp);
        end
    endtask

    // Transaction-level reference: each DUT is idle unless a capture happened within LAT+1 cycles.
    int           cap [2] = '{-1, -1};
    logic         m_we [2];
    logic [31:0]  m_addr [2];
    logic [255:0] m_wdata [2];
    logic [255:0] mm [2][64];
    bit           mv [2][64];
    logic [255:0] exp_rd [2];
    bit           rd_known [2] = '{1'b0, 1'b0};
    bit           b_exp, a_exp, oor_m;
    int           l_m, w_m;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            l_m = lat_of(i);
            if (!rst_n) begin
                cap[i]      = -1;
                exp_rd[i]   = '0;
                rd_known[i] = 1'b1;
            end
            b_exp = (cap[i] >= 0) && (cyc > cap[i]) && (cyc <= cap[i] + l_m + 1);
            a_exp = (cap[i] >= 0) && (cyc == cap[i] + l_m + 1);
            if (a_exp) begin
                oor_m = (m_addr[i] >= 32'd2048);
                w_m   = int'((m_addr[i] >> 5) & 32'd63);
                chk("err", i, err[i], oor_m);
                if (m_we[i]) begin
                    if (!oor_m) begin
                        mm[i][w_m] = m_wdata[i];
                        mv[i][w_m] = 1'b1;
                    end
                end else begin
                    exp_rd[i]   = oor_m ? '0 : mm[i][w_m];
                    rd_known[i] = oor_m || mv[i][w_m];
                end
            end
            chk("ack", i, ack[i], a_exp);
            chk("busy", i, busy[i], b_exp);
            if (rd_known[i]) chk("rdata", i, rdata[i], exp_rd[i]);
            if (rst_n && !b_exp && req[i]) begin
                cap[i]     = cyc;
                m_we[i]    = we[i];
                m_addr[i]  = addr[i];
                m_wdata[i] = wdata[i];
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Starts at posedge+1 with the DUT idle; returns at posedge+1 of the cycle after ack.
    task automatic xact(input int i, input bit w, input logic [31:0] a, input logic [255:0] d,
                        input bit keep, output int lat_seen, output logic [255:0] rd, output logic e);
        int n;
        n = 0;
        lat_seen = -1;
        rd = '0;
        e = 1'b0;
        req[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = d;
        while (n < 40) begin
            @(negedge clk);
            if (ack[i]) begin
                lat_seen = n;
                rd = rdata[i];
                e = err[i];
                break;
            end
            n++;
            sync();
            we[i] = 1'($urandom);
            addr[i] = $urandom;
            wdata[i] = r256();
        end
        chk("ack_seen", i, lat_seen >= 0, 1'b1);
        sync();
        if (!keep) req[i] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int           lat;
        logic [255:0] rd, da, db, dz, dc, d1;
        logic         e;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b1; we[i] = 1'b1; addr[i] = 32'h40; wdata[i] = '1;
        end
        repeat (3) sync();
        for (int i = 0; i < 2; i++) begin
            chk("rst_ack", i, ack[i], 1'b0);
            chk("rst_rdata", i, rdata[i], '0);
            req[i] = 1'b0;
        end
        rst_n = 1'b1;
        repeat (3) sync();
        for (int i = 0; i < 2; i++) chk("post_rst_busy", i, busy[i], 1'b0);

        for (int i = 0; i < 2; i++) begin
            xact(i, 1'b1, 32'h40, {8{32'hDEADBEEF}}, 1'b0, lat, rd, e);
            chk("wr_latency", i, lat, (i == 0) ? 3 : 2);
            chk("wr_err", i, e, 1'b0);
            xact(i, 1'b0, 32'h40, r256(), 1'b0, lat, rd, e);
            chk("rd_latency", i, lat, (i == 0) ? 3 : 2);
            chk("rd_data", i, rd, {8{32'hDEADBEEF}});
            repeat (3) sync();
            chk("rd_hold", i, rdata[i], {8{32'hDEADBEEF}});

            dz = r256(); da = r256(); db = r256();
            xact(i, 1'b1, 32'h0, dz, 1'b0, lat, rd, e);
            xact(i, 1'b1, 32'h20, da, 1'b0, lat, rd, e);
            xact(i, 1'b0, 32'h3F, r256(), 1'b0, lat, rd, e);
            chk("alias_rd", i, rd, da);
            xact(i, 1'b0, 32'h0, r256(), 1'b0, lat, rd, e);
            chk("word0_rd", i, rd, dz);

            xact(i, 1'b1, 32'h800, db, 1'b0, lat, rd, e);
            chk("oor_wr_err", i, e, 1'b1);
            xact(i, 1'b0, 32'h800, r256(), 1'b0, lat, rd, e);
            chk("oor_rd_err", i, e, 1'b1);
            chk("oor_rd_zero", i, rd, '0);
            xact(i, 1'b0, 32'h0, r256(), 1'b0, lat, rd, e);
            chk("oor_word0", i, rd, dz);

            d1 = r256();
            xact(i, 1'b1, 32'h100, d1, 1'b1, lat, rd, e);
            xact(i, 1'b0, 32'h100, r256(), 1'b0, lat, rd, e);
            chk("b2b_spacing", i, lat, (i == 0) ? 3 : 2);
            chk("b2b_rd", i, rd, d1);
        end

        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h60; wdata[0] = r256();
        sync();
        rst_n = 1'b0; req[0] = 1'b0;
        repeat (2) sync();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("no_ack_after_rst", 0, ack[0], 1'b0);
        end
        sync();
        dc = r256();
        xact(0, 1'b1, 32'h60, dc, 1'b0, lat, rd, e);
        xact(0, 1'b0, 32'h60, r256(), 1'b0, lat, rd, e);
        chk("rst_mid_rd", 0, rd, dc);

        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < 80; t++) begin
                logic [31:0] a;
                bit          kp;
                if ($urandom_range(0, 5) == 0) a = $urandom | 32'h800;
                else a = $urandom_range(0, 2047);
                kp = (t != 79) && ($urandom_range(0, 3) == 0);
                xact(i, 1'($urandom), a, r256(), kp, lat, rd, e);
                if (!kp) repeat ($urandom_range(0, 2)) sync();
            end
        end

        repeat (4) sync();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
